// File: rtl/sized_fifo0_pkg.sv
// Shared definitions for the sized_fifo0 family of occupancy trackers:
// the log2-ceiling helper and the legal parameter range limits.
package sized_fifo0_pkg;

  localparam int MIN_DEPTH    = 2;
  localparam int MIN_BURST    = 1;
  localparam int MIN_AF_LEVEL = 1;
  localparam int MIN_AE_LEVEL = 0;

  // Smallest r such that 2**r >= value.
  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sized_fifo0_flags.sv
// Combinational decode of a FIFO level into free space and status flags.
module sized_fifo0_flags
  import sized_fifo0_pkg::*;
#(
  parameter int p1depth      = 8,
  parameter int p2cntr_width = 4,
  parameter int p5af_level   = 6,
  parameter int p6ae_level   = 2
) (
  input  logic [p2cntr_width:0]   level,
  output logic [p2cntr_width-1:0] space,
  output logic                    empty_n,
  output logic                    full_n,
  output logic                    almost_full,
  output logic                    almost_empty
);

  localparam logic [p2cntr_width:0] DEPTH_L = (p2cntr_width + 1)'(p1depth);
  localparam logic [p2cntr_width:0] AF_L    = (p2cntr_width + 1)'(p5af_level);
  localparam logic [p2cntr_width:0] AE_L    = (p2cntr_width + 1)'(p6ae_level);

  always_comb begin
    space        = p2cntr_width'(DEPTH_L - level);
    empty_n      = (level != '0);
    full_n       = (level != DEPTH_L);
    almost_full  = (level >= AF_L);
    almost_empty = (level <= AE_L);
  end

endmodule

// File: rtl/sized_fifo0_burst.sv
// Multi-token FIFO occupancy tracker with registered level, space and flags.
// Optional sticky ENQ_ERR/DEQ_ERR outputs under SIZED_FIFO0_BURST_ERR_FLAGS_EN.
module sized_fifo0_burst
  import sized_fifo0_pkg::*;
#(
  parameter int p1depth       = 8,
  parameter int p2cntr_width  = 4,
  parameter int p3max_burst   = 4,
  parameter int p4burst_width = 3,
  parameter int p5af_level    = 6,
  parameter int p6ae_level    = 2,
  parameter int guarded       = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CLR,
  input  logic                     ENQ,
  input  logic [p4burst_width-1:0] ENQ_CNT,
  input  logic                     DEQ,
  input  logic [p4burst_width-1:0] DEQ_CNT,
`ifdef SIZED_FIFO0_BURST_ERR_FLAGS_EN
  output logic                     ENQ_ERR,
  output logic                     DEQ_ERR,
`endif
  output logic [p2cntr_width-1:0]  COUNT,
  output logic [p2cntr_width-1:0]  SPACE,
  output logic                     EMPTY_N,
  output logic                     FULL_N,
  output logic                     ALMOST_FULL,
  output logic                     ALMOST_EMPTY
);

  localparam int CW = p2cntr_width;
  localparam int BW = p4burst_width;
  localparam logic [BW-1:0] MAX_B = BW'(p3max_burst);

  if (p1depth < MIN_DEPTH) begin : g_bad_depth
    $error("sized_fifo0_burst: p1depth must be > 1");
  end
  if (p2cntr_width != log2_ceil(p1depth + 1)) begin : g_bad_cntr_width
    $error("sized_fifo0_burst: p2cntr_width must equal log2_ceil(p1depth+1)");
  end
  if (p3max_burst < MIN_BURST || p3max_burst > p1depth) begin : g_bad_burst
    $error("sized_fifo0_burst: p3max_burst must be in 1..p1depth");
  end
  if (p4burst_width != log2_ceil(p3max_burst + 1)) begin : g_bad_burst_width
    $error("sized_fifo0_burst: p4burst_width must equal log2_ceil(p3max_burst+1)");
  end
  if (p5af_level < MIN_AF_LEVEL || p5af_level > p1depth) begin : g_bad_af
    $error("sized_fifo0_burst: p5af_level must be in 1..p1depth");
  end
  if (p6ae_level < MIN_AE_LEVEL || p6ae_level > p1depth - 1) begin : g_bad_ae
    $error("sized_fifo0_burst: p6ae_level must be in 0..p1depth-1");
  end
  if (guarded != 0 && guarded != 1) begin : g_bad_guarded
    $error("sized_fifo0_burst: guarded must be 0 or 1");
  end

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] space_q, space_d;
  logic          empty_n_q, empty_n_d;
  logic          full_n_q, full_n_d;
  logic          almost_full_q, almost_full_d;
  logic          almost_empty_q, almost_empty_d;

  logic [CW:0]   enq_cnt_x, deq_cnt_x;
  logic [CW:0]   acc_enq, acc_deq, enq_room, level_next;
  logic          enq_ok, deq_ok;

  // Dequeue is decided first so an unguarded enqueue can reuse its freed space.
  always_comb begin
    enq_cnt_x  = (CW + 1)'(ENQ_CNT);
    deq_cnt_x  = (CW + 1)'(DEQ_CNT);
    deq_ok     = DEQ && (DEQ_CNT != '0) && (DEQ_CNT <= MAX_B)
                 && (deq_cnt_x <= {1'b0, count_q});
    acc_deq    = deq_ok ? deq_cnt_x : '0;
    enq_room   = {1'b0, space_q} + ((guarded != 0) ? '0 : acc_deq);
    enq_ok     = ENQ && (ENQ_CNT != '0) && (ENQ_CNT <= MAX_B)
                 && (enq_cnt_x <= enq_room);
    acc_enq    = enq_ok ? enq_cnt_x : '0;
    level_next = CLR ? '0 : ({1'b0, count_q} + acc_enq - acc_deq);
    count_d    = level_next[CW-1:0];
  end

  sized_fifo0_flags #(
    .p1depth      (p1depth),
    .p2cntr_width (p2cntr_width),
    .p5af_level   (p5af_level),
    .p6ae_level   (p6ae_level)
  ) u_flags (
    .level        (level_next),
    .space        (space_d),
    .empty_n      (empty_n_d),
    .full_n       (full_n_d),
    .almost_full  (almost_full_d),
    .almost_empty (almost_empty_d)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q        <= '0;
      space_q        <= CW'(p1depth);
      empty_n_q      <= 1'b0;
      full_n_q       <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      count_q        <= count_d;
      space_q        <= space_d;
      empty_n_q      <= empty_n_d;
      full_n_q       <= full_n_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign COUNT        = count_q;
  assign SPACE        = space_q;
  assign EMPTY_N      = empty_n_q;
  assign FULL_N       = full_n_q;
  assign ALMOST_FULL  = almost_full_q;
  assign ALMOST_EMPTY = almost_empty_q;

`ifdef SIZED_FIFO0_BURST_ERR_FLAGS_EN
  logic enq_err_q, enq_err_d;
  logic deq_err_q, deq_err_d;

  // Zero-count requests are no-ops and never count as errors.
  always_comb begin
    enq_err_d = CLR ? 1'b0 : (enq_err_q | (ENQ && (ENQ_CNT != '0) && !enq_ok));
    deq_err_d = CLR ? 1'b0 : (deq_err_q | (DEQ && (DEQ_CNT != '0) && !deq_ok));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      enq_err_q <= 1'b0;
      deq_err_q <= 1'b0;
    end else begin
      enq_err_q <= enq_err_d;
      deq_err_q <= deq_err_d;
    end
  end

  assign ENQ_ERR = enq_err_q;
  assign DEQ_ERR = deq_err_q;
`endif

endmodule

// File: tb/tb_sized_fifo0_burst.sv
// Scoreboard bench for sized_fifo0_burst: a guarded and an unguarded instance
// share stimulus and are compared against a behavioural level model.
module tb_sized_fifo0_burst;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       CLR = 1'b0;
  logic       ENQ = 1'b0;
  logic [2:0] ENQ_CNT = '0;
  logic       DEQ = 1'b0;
  logic [2:0] DEQ_CNT = '0;

  logic [3:0] g_count, g_space, u_count, u_space;
  logic       g_empty_n, g_full_n, g_af, g_ae;
  logic       u_empty_n, u_full_n, u_af, u_ae;
`ifdef SIZED_FIFO0_BURST_ERR_FLAGS_EN
  logic       g_enq_err, g_deq_err, u_enq_err, u_deq_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int count;
    int space;
    bit empty_n;
    bit full_n;
    bit af;
    bit ae;
    bit enq_err;
    bit deq_err;
  } exp_t;

  exp_t sb_g[$];
  exp_t sb_u[$];

  int m_count[2];
  bit m_enq_err[2];
  bit m_deq_err[2];

  always #5 CLK = ~CLK;

  sized_fifo0_burst #(.guarded(1)) dut_g (
    .CLK(CLK), .RST(RST), .CLR(CLR),
    .ENQ(ENQ), .ENQ_CNT(ENQ_CNT), .DEQ(DEQ), .DEQ_CNT(DEQ_CNT),
`ifdef SIZED_FIFO0_BURST_ERR_FLAGS_EN
    .ENQ_ERR(g_enq_err), .DEQ_ERR(g_deq_err),
`endif
    .COUNT(g_count), .SPACE(g_space), .EMPTY_N(g_empty_n), .FULL_N(g_full_n),
    .ALMOST_FULL(g_af), .ALMOST_EMPTY(g_ae)
  );

  sized_fifo0_burst #(.guarded(0)) dut_u (
    .CLK(CLK), .RST(RST), .CLR(CLR),
    .ENQ(ENQ), .ENQ_CNT(ENQ_CNT), .DEQ(DEQ), .DEQ_CNT(DEQ_CNT),
`ifdef SIZED_FIFO0_BURST_ERR_FLAGS_EN
    .ENQ_ERR(u_enq_err), .DEQ_ERR(u_deq_err),
`endif
    .COUNT(u_count), .SPACE(u_space), .EMPTY_N(u_empty_n), .FULL_N(u_full_n),
    .ALMOST_FULL(u_af), .ALMOST_EMPTY(u_ae)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: depth 8, max burst 4, af 6, ae 2.
  task automatic model_step(input int idx, input bit grd, input bit rst, input bit clr,
                            input bit enq, input int ecnt, input bit deq, input int dcnt);
    bit deq_ok, enq_ok;
    int room, ad, ae_n;
    if (rst || clr) begin
      m_count[idx]   = 0;
      m_enq_err[idx] = 0;
      m_deq_err[idx] = 0;
      return;
    end
    deq_ok = deq && dcnt > 0 && dcnt <= 4 && dcnt <= m_count[idx];
    ad     = deq_ok ? dcnt : 0;
    room   = 8 - m_count[idx] + (grd ? 0 : ad);
    enq_ok = enq && ecnt > 0 && ecnt <= 4 && ecnt <= room;
    ae_n   = enq_ok ? ecnt : 0;
    if (enq && ecnt != 0 && !enq_ok) m_enq_err[idx] = 1;
    if (deq && dcnt != 0 && !deq_ok) m_deq_err[idx] = 1;
    m_count[idx] = m_count[idx] + ae_n - ad;
  endtask

  function automatic exp_t make_exp(input int idx);
    exp_t e;
    e.count   = m_count[idx];
    e.space   = 8 - m_count[idx];
    e.empty_n = (m_count[idx] != 0);
    e.full_n  = (m_count[idx] != 8);
    e.af      = (m_count[idx] >= 6);
    e.ae      = (m_count[idx] <= 2);
    e.enq_err = m_enq_err[idx];
    e.deq_err = m_deq_err[idx];
    return e;
  endfunction

  task automatic compare_outputs();
    exp_t e;
    if (sb_g.size() == 0 || sb_u.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_g.pop_front();
    checkOutput("g.count",   32'(g_count),   32'(e.count));
    checkOutput("g.space",   32'(g_space),   32'(e.space));
    checkOutput("g.empty_n", 32'(g_empty_n), 32'(e.empty_n));
    checkOutput("g.full_n",  32'(g_full_n),  32'(e.full_n));
    checkOutput("g.af",      32'(g_af),      32'(e.af));
    checkOutput("g.ae",      32'(g_ae),      32'(e.ae));
`ifdef SIZED_FIFO0_BURST_ERR_FLAGS_EN
    checkOutput("g.enq_err", 32'(g_enq_err), 32'(e.enq_err));
    checkOutput("g.deq_err", 32'(g_deq_err), 32'(e.deq_err));
`endif
    e = sb_u.pop_front();
    checkOutput("u.count",   32'(u_count),   32'(e.count));
    checkOutput("u.space",   32'(u_space),   32'(e.space));
    checkOutput("u.empty_n", 32'(u_empty_n), 32'(e.empty_n));
    checkOutput("u.full_n",  32'(u_full_n),  32'(e.full_n));
    checkOutput("u.af",      32'(u_af),      32'(e.af));
    checkOutput("u.ae",      32'(u_ae),      32'(e.ae));
`ifdef SIZED_FIFO0_BURST_ERR_FLAGS_EN
    checkOutput("u.enq_err", 32'(u_enq_err), 32'(e.enq_err));
    checkOutput("u.deq_err", 32'(u_deq_err), 32'(e.deq_err));
`endif
  endtask

  // Drive one cycle, push the model's prediction, then compare after the edge.
  task automatic applyStimulus(input bit rst, input bit clr, input bit enq, input int ecnt,
                               input bit deq, input int dcnt);
    RST     = rst;
    CLR     = clr;
    ENQ     = enq;
    ENQ_CNT = 3'(ecnt);
    DEQ     = deq;
    DEQ_CNT = 3'(dcnt);
    model_step(0, 1'b1, rst, clr, enq, ecnt, deq, dcnt);
    model_step(1, 1'b0, rst, clr, enq, ecnt, deq, dcnt);
    sb_g.push_back(make_exp(0));
    sb_u.push_back(make_exp(1));
    @(posedge CLK);
    #1;
    compare_outputs();
  endtask

  initial begin
    @(posedge CLK);
    #1;
    // Reset held two cycles with an enqueue pending
    applyStimulus(1, 0, 1, 3, 0, 0);
    applyStimulus(1, 0, 1, 3, 0, 0);
    // Fill, over-fill rejection, reach full
    applyStimulus(0, 0, 1, 4, 0, 0);
    applyStimulus(0, 0, 1, 2, 0, 0);
    applyStimulus(0, 0, 1, 3, 0, 0);
    applyStimulus(0, 0, 1, 2, 0, 0);
    // Simultaneous enq/deq at full: guarded drops to 6, unguarded stays 8
    applyStimulus(0, 0, 1, 2, 1, 2);
    // Over-dequeue from 3, then exact drain
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 3, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 4);
    applyStimulus(0, 0, 0, 0, 1, 3);
    // Illegal and zero counts
    applyStimulus(0, 0, 1, 5, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 7);
    // Clear wins over a same-cycle enq/deq, then normal operation resumes
    applyStimulus(0, 0, 1, 4, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 2, 1, 1);
    applyStimulus(0, 0, 1, 2, 0, 0);
    // Reset asserted mid-burst
    applyStimulus(0, 0, 1, 4, 1, 1);
    applyStimulus(1, 0, 1, 4, 1, 1);
    // Random traffic
    for (int i = 0; i < 80; i++) begin
      applyStimulus(0, ($urandom_range(0, 15) == 0), $urandom_range(0, 1),
                    int'($urandom_range(0, 7)), $urandom_range(0, 1),
                    int'($urandom_range(0, 7)));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
